// File: rtl/exp3_unidade_controle.sv
// Control unit for the experiment-3 memory game: sequences latch/compare/advance over 16 plays.
// Optional play timeout in espera is built when macro TIMEOUT_EN is defined.
module exp3_unidade_controle #(
   parameter int TIMEOUT_CICLOS = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       chavesIgualMemoria,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARACAO  = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTOU = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERROU   = 4'hE
   } estado_t;

   estado_t    estado_r;
   estado_t    proximo_s;
   logic       jogada_d_r;
   logic       jogada_pulso_s;
   logic       expirou_s;
   logic [7:0] saidas_r;

   // Output vector order: {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
   function automatic logic [7:0] decode_saidas(input estado_t e);
      logic [7:0] s;
      case (e)
         PREPARACAO:  s = 8'b1010_0000;
         REGISTRA:    s = 8'b0001_0000;
         PROXIMO:     s = 8'b0100_0000;
         FIM_ACERTOU: s = 8'b0000_1100;
         FIM_ERROU:   s = 8'b0000_1010;
`ifdef TIMEOUT_EN
         FIM_TIMEOUT: s = 8'b0000_1011;
`endif
         default:     s = 8'b0000_0000;
      endcase
      return s;
   endfunction

   assign jogada_pulso_s = jogada & ~jogada_d_r;

`ifdef TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
   logic [CNT_W-1:0] cont_r;

   // Espera cycle counter, cleared whenever the FSM is elsewhere
   always_ff @(posedge clock) begin
      if (reset) begin
         cont_r <= {CNT_W{1'b0}};
      end else if (estado_r != ESPERA) begin
         cont_r <= {CNT_W{1'b0}};
      end else begin
         cont_r <= cont_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign expirou_s = (estado_r == ESPERA) && (cont_r == CNT_W'(TIMEOUT_CICLOS - 1));
`else
   logic unused_cfg_s;
   assign unused_cfg_s = ^TIMEOUT_CICLOS;
   assign expirou_s    = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      proximo_s = INICIAL;
      case (estado_r)
         INICIAL: begin
            if (iniciar) proximo_s = PREPARACAO;
            else         proximo_s = INICIAL;
         end
         PREPARACAO: proximo_s = ESPERA;
         ESPERA: begin
            // A play on the last allowed cycle beats the timeout
            if (jogada_pulso_s) proximo_s = REGISTRA;
            else if (expirou_s) proximo_s = FIM_TIMEOUT;
            else                proximo_s = ESPERA;
         end
         REGISTRA: proximo_s = COMPARACAO;
         COMPARACAO: begin
            if (!chavesIgualMemoria) proximo_s = FIM_ERROU;
            else if (fimC)           proximo_s = FIM_ACERTOU;
            else                     proximo_s = PROXIMO;
         end
         PROXIMO: proximo_s = ESPERA;
`ifdef TIMEOUT_EN
         FIM_TIMEOUT,
`endif
         FIM_ACERTOU, FIM_ERROU: begin
            if (iniciar) proximo_s = PREPARACAO;
            else         proximo_s = estado_r;
         end
         default: proximo_s = INICIAL;
      endcase
   end

   // State, edge-detect and registered Moore outputs (decoded from the state being entered)
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_r   <= INICIAL;
         jogada_d_r <= 1'b0;
         saidas_r   <= 8'b0000_0000;
      end else begin
         estado_r   <= proximo_s;
         jogada_d_r <= jogada;
         saidas_r   <= decode_saidas(proximo_s);
      end
   end

   assign {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} = saidas_r;
   assign db_estado = estado_r;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Self-checking bench for exp3_unidade_controle: vector table plus multi-cycle play sequences.
// Timeout checks adapt to whether TIMEOUT_EN is defined.
module tb_exp3_unidade_controle;

   logic       clock = 1'b0;
   logic       reset, iniciar, jogada, chavesIgualMemoria, fimC;
   logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_ESP = 4'h2, S_REG = 4'h4,
                          S_CMP = 4'h5, S_PROX = 4'h6, S_ACE = 4'hA, S_TMO = 4'hD, S_ERR = 4'hE;
   // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
   localparam logic [7:0] O_NONE = 8'h00, O_PREP = 8'hA0, O_REG = 8'h10, O_PROX = 8'h40,
                          O_ACE = 8'h0C, O_ERR = 8'h0A, O_TMO = 8'h0B;

   typedef struct {
      logic       r, i, j, e, f;
      logic [3:0] st;
      logic [7:0] o;
   } vec_t;

   typedef struct {
      string      nm;
      logic [3:0] st;
      logic [7:0] o;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[24];
   int   n_cmp = 0, n_err = 0;
   int   n_reg = 0, n_conta = 0;

   exp3_unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
      .chavesIgualMemoria(chavesIgualMemoria), .fimC(fimC),
      .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
      .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (registraR) n_reg++;
      if (contaC) n_conta++;
   end

   task automatic step(input logic r, i, j, e, f, input logic [3:0] st, input logic [7:0] o,
                       input string nm);
      exp_t x;
      logic [7:0] act;
      @(negedge clock);
      reset = r; iniciar = i; jogada = j; chavesIgualMemoria = e; fimC = f;
      sb.push_back('{nm, st, o});
      @(posedge clock);
      #1;
      x   = sb.pop_front();
      act = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
      n_cmp++;
      if (db_estado !== x.st || act !== x.o) begin
         n_err++;
         $display("FAIL %s: got estado=%h outs=%b, expected estado=%h outs=%b",
                  x.nm, db_estado, act, x.st, x.o);
      end
   endtask

   task automatic check_cnt(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   // One play starting in espera; ends in espera (correct, not last) or in an end state
   task automatic play(input logic e, f, input string nm);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_REG, O_REG, {nm, "_reg"});
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_CMP, O_NONE, {nm, "_cmp"});
      if (!e) begin
         step(1'b0, 1'b0, 1'b0, e, f, S_ERR, O_ERR, {nm, "_err"});
      end else if (f) begin
         step(1'b0, 1'b0, 1'b0, e, f, S_ACE, O_ACE, {nm, "_ace"});
      end else begin
         step(1'b0, 1'b0, 1'b0, e, f, S_PROX, O_PROX, {nm, "_prox"});
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, {nm, "_esp"});
      end
   endtask

   initial begin
      reset = 1'b1; iniciar = 1'b1; jogada = 1'b1; chavesIgualMemoria = 1'b0; fimC = 1'b0;
      //          r     i     j     e     f     state   outs
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_INI,  O_NONE};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_INI,  O_NONE};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_PREP, O_PREP};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_REG,  O_REG};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_CMP,  O_NONE};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_PROX, O_PROX};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_REG,  O_REG};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_CMP,  O_NONE};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_ERR,  O_ERR};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_ERR,  O_ERR};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_PREP, O_PREP};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP,  O_NONE};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_REG,  O_REG};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CMP,  O_NONE};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_ACE,  O_ACE};
      tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ACE,  O_ACE};
      tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_PREP, O_PREP};
      tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP,  O_NONE};

      for (int k = 0; k < 24; k++) begin
         step(tbl[k].r, tbl[k].i, tbl[k].j, tbl[k].e, tbl[k].f, tbl[k].st, tbl[k].o,
              $sformatf("vec%0d", k));
      end

      // Full winning game: 16 plays, fimC only on the last
      n_reg = 0; n_conta = 0;
      for (int k = 0; k < 16; k++) begin
         play(1'b1, (k == 15), $sformatf("win_p%0d", k));
      end
      check_cnt("win_registraR_pulses", n_reg, 16);
      check_cnt("win_contaC_pulses", n_conta, 15);

      // Mismatch on play 3
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_PREP, O_PREP, "lose_prep");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "lose_esp");
      n_reg = 0; n_conta = 0;
      play(1'b1, 1'b0, "lose_p0");
      play(1'b1, 1'b0, "lose_p1");
      play(1'b0, 1'b0, "lose_p2");
      check_cnt("lose_contaC_pulses", n_conta, 2);

      // Button held 20 cycles: one registration only
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_PREP, O_PREP, "hold_prep");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "hold_esp");
      n_reg = 0;
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_REG, O_REG, "hold_reg");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_CMP, O_NONE, "hold_cmp");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_PROX, O_PROX, "hold_prox");
      for (int k = 0; k < 17; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_ESP, O_NONE, $sformatf("hold_esp%0d", k));
      end
      check_cnt("hold_registraR_pulses", n_reg, 1);

      // Reset in comparacao, then restart
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "rst_esp");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_REG, O_REG, "rst_reg");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CMP, O_NONE, "rst_cmp");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_INI, O_NONE, "rst_apply");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_INI, O_NONE, "rst_idle");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_PREP, O_PREP, "rst_restart");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "tmo_esp0");

      // Idle espera: timeout after 8 cycles only when the feature is built
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, $sformatf("tmo_wait%0d", k));
      end
`ifdef TIMEOUT_EN
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_TMO, O_TMO, "tmo_fire");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_TMO, O_TMO, "tmo_hold");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_PREP, O_PREP, "tmo_restart");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "tmo2_esp0");
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, $sformatf("tmo2_wait%0d", k));
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_REG, O_REG, "tmo2_pulse_wins");
`else
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "notmo_8");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_ESP, O_NONE, "notmo_iniciar_ignored");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_REG, O_REG, "notmo_pulse");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/exp3_unidade_controle.md
Name: exp3_unidade_controle

Overview:
Moore-style control unit for the experiment-3 memory-game system, driving the data-flow block that holds the address counter, the 16x4 sync ROM, the switch register and the comparator. It sequences each play: wait for the play button, latch the switches, compare against ROM, then advance or finish. It consumes chavesIgualMemoria/fimC and produces zeraC/contaC/zeraR/registraR plus game status and a debug state code.

Parameters:
TIMEOUT_CICLOS, 5000, cycles allowed in espera before timeout (used only with TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high; forces state inicial
iniciar  input  1  level; starts/restarts a game from inicial or any end state
jogada  input  1  level from play button; internally edge-detected
chavesIgualMemoria  input  1  comparator result from data flow
fimC  input  1  counter rco (address 15) from data flow
zeraC  output  1  clear address counter
contaC  output  1  increment address counter
zeraR  output  1  clear switch register
registraR  output  1  load switch register
pronto  output  1  game finished
acertou  output  1  game finished, all 16 plays correct
errou  output  1  game finished, wrong play (or timeout)
timeout  output  1  game finished by timeout (0 when feature absent)
db_estado  output  4  current state code

Behaviour:
- Edge detector: jogada_d register (reset 0); jogada_pulso = jogada & ~jogada_d. Held button = one pulse. Pulses outside espera ignored (not queued).
- State register reset -> inicial. Outputs decoded purely from state (no input-to-output combinational paths).
- States/codes (db_estado) and outputs (unlisted outputs 0):
  - inicial 0x0: all outputs 0. iniciar=1 -> preparacao; else stay.
  - preparacao 0x1: zeraC=1, zeraR=1. -> espera unconditionally.
  - espera 0x2: no outputs. jogada_pulso -> registra; else stay.
  - registra 0x4: registraR=1. -> comparacao.
  - comparacao 0x5: no outputs. chavesIgualMemoria=0 -> fim_errou; else fimC=1 -> fim_acertou; else -> proximo. Mismatch has priority over fimC.
  - proximo 0x6: contaC=1. -> espera.
  - fim_acertou 0xA: pronto=1, acertou=1. iniciar=1 -> preparacao; else stay.
  - fim_errou 0xE: pronto=1, errou=1. iniciar=1 -> preparacao; else stay.
  - fim_timeout 0xD (feature only): pronto=1, errou=1, timeout=1. iniciar=1 -> preparacao.
  - Any unused code -> inicial next cycle.
- Timing: minimum play = espera(>=1) + registra + comparacao + proximo = 4 cycles. Sync-ROM latency is covered: address changes at end of proximo, ROM output valid before comparacao.
- Reset mid-game: next edge state=inicial, all outputs 0, jogada_d=0, timeout counter=0; counter/register not cleared until preparacao.
- iniciar ignored in states other than inicial and end states; reset has priority over all inputs.

Optional Feature:
TIMEOUT_EN defined: counter (width clog2(TIMEOUT_CICLOS)) cleared on any non-espera state, increments each espera cycle; if in espera with count = TIMEOUT_CICLOS-1 and no jogada_pulso -> fim_timeout. A pulse on that same cycle wins (-> registra). Not defined: no counter, fim_timeout unreachable, timeout tied 0, parameter unused.

Test Plan:
- Reset held 2 cycles with iniciar=1, jogada=1 -> db_estado=0x0, all outputs 0; release reset -> preparacao (zeraC=zeraR=1 one cycle) then espera 0x2.
- 16 plays with chavesIgualMemoria=1, fimC=1 only on 16th -> exactly 16 registraR pulses, 15 contaC pulses, ends 0xA, pronto=acertou=1, errou=0.
- Correct plays 1-2, chavesIgualMemoria=0 on play 3 -> 0xE, pronto=errou=1, 2 contaC pulses total; mismatch with fimC=1 also -> 0xE.
- jogada held high 20 cycles in espera -> exactly one registraR pulse; pulse in proximo ignored, FSM stays in espera.
- Reset asserted in comparacao -> 0x0 next cycle; then iniciar -> preparacao; from 0xE iniciar=1 -> 0x1.
- TIMEOUT_EN, TIMEOUT_CICLOS=8: no jogada in espera -> 0xD after 8 espera cycles, timeout=errou=pronto=1; pulse on 8th cycle -> 0x4 instead.
